// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, execute-stage state encoding and the
// execute-stage entry record.
package cpu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLT  = 4'd2;
  localparam logic [3:0] ALU_SLTU = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_XOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  typedef enum logic [1:0] {
    EXE_EMPTY = 2'd0,
    EXE_ONE   = 2'd1,
    EXE_TWO   = 2'd2
  } exe_state_t;

  // Fixed-width fields of an entry; the XLEN-wide operands are stored
  // alongside it because their width is a module parameter.
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  alu_op;
    logic [4:0]  dest;
    logic        gr_we;
  } exe_entry_t;

endpackage

// File: rtl/exe_skid_buf.sv
// Two-entry (head + skid) buffer of the execute stage with its state machine
// and both valid/allowin handshakes.
module exe_skid_buf
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ds_to_es_valid,
  output logic             es_allowin,
  input  exe_entry_t       ds_entry,
  input  logic [XLEN-1:0]  ds_src1,
  input  logic [XLEN-1:0]  ds_src2,
  input  logic             ms_allowin,
  output logic             es_to_ms_valid,
  output exe_entry_t       head,
  output logic [XLEN-1:0]  head_src1,
  output logic [XLEN-1:0]  head_src2,
  output exe_state_t       state
);

  exe_entry_t      skid;
  logic [XLEN-1:0] skid_src1;
  logic [XLEN-1:0] skid_src2;
  exe_state_t      state_nxt;
  logic            push;
  logic            pop;
  logic            load_head;
  logic            load_skid;
  logic            shift_skid;

  // Handshake: a transfer happens on a rising edge where valid and allowin
  // are both high; allowin never depends on the sender's valid, and
  // es_allowin comes from the state register only (plus reset).
  assign es_allowin     = ~reset & (state != EXE_TWO);
  assign es_to_ms_valid = (state != EXE_EMPTY);
  assign push           = ds_to_es_valid & es_allowin;
  assign pop            = es_to_ms_valid & ms_allowin;

  always_comb begin
    state_nxt  = state;
    load_head  = 1'b0;
    load_skid  = 1'b0;
    shift_skid = 1'b0;
    if (flush) begin
      state_nxt = EXE_EMPTY;
    end else begin
      case (state)
        EXE_EMPTY: begin
          if (push) begin
            state_nxt = EXE_ONE;
            load_head = 1'b1;
          end
        end
        EXE_ONE: begin
          if (push && pop) begin
            load_head = 1'b1;
          end else if (push) begin
            state_nxt = EXE_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EXE_EMPTY;
          end
        end
        EXE_TWO: begin
          if (pop) begin
            state_nxt  = EXE_ONE;
            shift_skid = 1'b1;
          end
        end
        default: state_nxt = EXE_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= EXE_EMPTY;
    else       state <= state_nxt;
  end

  // Payloads carry no reset; they are only meaningful while the state says so.
  always_ff @(posedge clk) begin
    if (load_head) begin
      head      <= ds_entry;
      head_src1 <= ds_src1;
      head_src2 <= ds_src2;
    end else if (shift_skid) begin
      head      <= skid;
      head_src1 <= skid_src1;
      head_src2 <= skid_src2;
    end
    if (load_skid) begin
      skid      <= ds_entry;
      skid_src1 <= ds_src1;
      skid_src2 <= ds_src2;
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: skid-buffered decode->memory handshake plus the ALU on the
// head entry. Define EXE_FWD_EN to enable the head-entry forwarding outputs.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             es_flush,
  input  logic             ds_to_es_valid,
  output logic             es_allowin,
  input  logic [31:0]      ds_pc,
  input  logic [3:0]       ds_alu_op,
  input  logic [XLEN-1:0]  ds_src1,
  input  logic [XLEN-1:0]  ds_src2,
  input  logic [4:0]       ds_dest,
  input  logic             ds_gr_we,
  input  logic             ms_allowin,
  output logic             es_to_ms_valid,
  output logic [31:0]      es_pc,
  output logic [XLEN-1:0]  es_alu_res,
  output logic [4:0]       es_dest,
  output logic             es_gr_we,
  output logic             es_fwd_valid,
  output logic [4:0]       es_fwd_dest,
  output logic [XLEN-1:0]  es_fwd_data,
  output exe_state_t       es_state
);

  exe_entry_t      ds_entry;
  exe_entry_t      head;
  logic [XLEN-1:0] head_src1;
  logic [XLEN-1:0] head_src2;
  logic [4:0]      shamt;

  assign ds_entry = '{pc: ds_pc, alu_op: ds_alu_op, dest: ds_dest, gr_we: ds_gr_we};

  exe_skid_buf #(.XLEN(XLEN)) u_skid_buf (
    .clk            (clk),
    .reset          (reset),
    .flush          (es_flush),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .ds_entry       (ds_entry),
    .ds_src1        (ds_src1),
    .ds_src2        (ds_src2),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .head           (head),
    .head_src1      (head_src1),
    .head_src2      (head_src2),
    .state          (es_state)
  );

  assign es_pc    = head.pc;
  assign es_dest  = head.dest;
  assign es_gr_we = head.gr_we;
  assign shamt    = head_src1[4:0];

  // Shifts move src2 by src1[4:0]; LUI places src2's low half in the top half.
  always_comb begin
    es_alu_res = '0;
    case (head.alu_op)
      ALU_ADD:  es_alu_res = head_src1 + head_src2;
      ALU_SUB:  es_alu_res = head_src1 - head_src2;
      ALU_SLT:  es_alu_res = {{(XLEN-1){1'b0}}, $signed(head_src1) < $signed(head_src2)};
      ALU_SLTU: es_alu_res = {{(XLEN-1){1'b0}}, head_src1 < head_src2};
      ALU_AND:  es_alu_res = head_src1 & head_src2;
      ALU_NOR:  es_alu_res = ~(head_src1 | head_src2);
      ALU_OR:   es_alu_res = head_src1 | head_src2;
      ALU_XOR:  es_alu_res = head_src1 ^ head_src2;
      ALU_SLL:  es_alu_res = head_src2 << shamt;
      ALU_SRL:  es_alu_res = head_src2 >> shamt;
      ALU_SRA:  es_alu_res = $signed(head_src2) >>> shamt;
      ALU_LUI:  es_alu_res = head_src2 << 16;
      default:  es_alu_res = '0;
    endcase
  end

`ifdef EXE_FWD_EN
  assign es_fwd_valid = es_to_ms_valid & es_gr_we & (es_dest != 5'd0);
  assign es_fwd_dest  = es_dest;
  assign es_fwd_data  = es_alu_res;
`else
  assign es_fwd_valid = 1'b0;
  assign es_fwd_dest  = 5'd0;
  assign es_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed scenarios plus a random
// back-pressure stream, with an in-order scoreboard on the memory-side port.
module tb_exe_stage;
  import cpu_pkg::*;

  localparam int XLEN = 32;
  localparam int EW   = 70;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            es_flush = 1'b0;
  logic            ds_to_es_valid = 1'b0;
  logic            es_allowin;
  logic [31:0]     ds_pc = '0;
  logic [3:0]      ds_alu_op = '0;
  logic [XLEN-1:0] ds_src1 = '0;
  logic [XLEN-1:0] ds_src2 = '0;
  logic [4:0]      ds_dest = '0;
  logic            ds_gr_we = 1'b0;
  logic            ms_allowin = 1'b0;
  logic            es_to_ms_valid;
  logic [31:0]     es_pc;
  logic [XLEN-1:0] es_alu_res;
  logic [4:0]      es_dest;
  logic            es_gr_we;
  logic            es_fwd_valid;
  logic [4:0]      es_fwd_dest;
  logic [XLEN-1:0] es_fwd_data;
  exe_state_t      es_state;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_exp;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            rand_bp = 1'b0;
  logic [31:0]   pc_next = 32'h0000_1000;

  exe_stage #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .es_flush       (es_flush),
    .ds_to_es_valid (ds_to_es_valid),
    .es_allowin     (es_allowin),
    .ds_pc          (ds_pc),
    .ds_alu_op      (ds_alu_op),
    .ds_src1        (ds_src1),
    .ds_src2        (ds_src2),
    .ds_dest        (ds_dest),
    .ds_gr_we       (ds_gr_we),
    .ms_allowin     (ms_allowin),
    .es_to_ms_valid (es_to_ms_valid),
    .es_pc          (es_pc),
    .es_alu_res     (es_alu_res),
    .es_dest        (es_dest),
    .es_gr_we       (es_gr_we),
    .es_fwd_valid   (es_fwd_valid),
    .es_fwd_dest    (es_fwd_dest),
    .es_fwd_data    (es_fwd_data),
    .es_state       (es_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      ms_allowin = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- reference ALU ----------------
  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ext;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a + ~b + 32'd1;
      4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:    return (a < b) ? 32'd1 : 32'd0;
      4'd4:    return a & b;
      4'd5:    return ~a & ~b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return b << a[4:0];
      4'd9:    return b >> a[4:0];
      4'd10: begin
        ext = {{32{b[31]}}, b} >> a[4:0];
        return ext[31:0];
      end
      4'd11:   return {b[15:0], 16'h0000};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && !es_flush && es_to_ms_valid && ms_allowin) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pc=%h res=%h, required no output (nothing pending)",
                 es_pc, es_alu_res);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({es_pc, es_alu_res, es_dest, es_gr_we} !== mon_exp) begin
          n_fail++;
          $display("FAIL sb_entry: got pc=%h res=%h dest=%0d we=%b, required pc=%h res=%h dest=%0d we=%b",
                   es_pc, es_alu_res, es_dest, es_gr_we,
                   mon_exp[69:38], mon_exp[37:6], mon_exp[5:1], mon_exp[0]);
        end
      end
`ifndef EXE_FWD_EN
      n_cmp++;
      if (es_fwd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL fwd_disabled: got es_fwd_valid=%b, required 0", es_fwd_valid);
      end
`endif
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] d, input logic we);
    bit ok = 1'b0;
    ds_to_es_valid = 1'b1;
    ds_pc = pc_next;
    ds_alu_op = op;
    ds_src1 = a;
    ds_src2 = b;
    ds_dest = d;
    ds_gr_we = we;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (es_allowin) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: es_allowin=0 for 50 cycles, required 1");
    end else begin
      exp_q.push_back({pc_next, alu_model(op, a, b), d, we});
    end
    @(posedge clk);
    #1;
    ds_to_es_valid = 1'b0;
    pc_next = pc_next + 32'd4;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (es_allowin !== 1'b0) begin
      n_fail++; $display("FAIL reset_allowin: got %b, required 0", es_allowin);
    end
    n_cmp++;
    if (es_to_ms_valid !== 1'b0 || es_fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got valid=%b fwd=%b, required 0/0", es_to_ms_valid, es_fwd_valid);
    end
    n_cmp++;
    if (es_state !== EXE_EMPTY) begin
      n_fail++; $display("FAIL reset_state: got %0d, required %0d", es_state, EXE_EMPTY);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got allowin=%b valid=%b, required 1/0", es_allowin, es_to_ms_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add;
    ms_allowin = 1'b1;
    send(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (es_to_ms_valid !== 1'b1 || es_alu_res !== 32'd12 || es_dest !== 5'd3) begin
      n_fail++;
      $display("FAIL single_add: got valid=%b res=%0d dest=%0d, required 1/12/3", es_to_ms_valid, es_alu_res, es_dest);
    end
`ifdef EXE_FWD_EN
    n_cmp++;
    if (es_fwd_valid !== 1'b1 || es_fwd_data !== 32'd12 || es_fwd_dest !== 5'd3) begin
      n_fail++;
      $display("FAIL single_add_fwd: got fv=%b fd=%0d fdst=%0d, required 1/12/3", es_fwd_valid, es_fwd_data, es_fwd_dest);
    end
`else
    n_cmp++;
    if (es_fwd_valid !== 1'b0 || es_fwd_data !== 32'd0) begin
      n_fail++; $display("FAIL single_add_nofwd: got fv=%b fd=%h, required 0/0", es_fwd_valid, es_fwd_data);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    logic [3:0]  t_op[10]  = '{ALU_SUB, ALU_SLTU, ALU_SLT, ALU_SRA, ALU_LUI,
                               ALU_SLL, ALU_SRL, ALU_NOR, ALU_XOR, 4'd13};
    logic [31:0] t_a[10]   = '{32'd3, 32'd1, 32'hFFFF_FFFF, 32'd4, 32'd0,
                               32'd36, 32'd8, 32'd0, 32'hFF00_FF00, 32'hDEAD_BEEF};
    logic [31:0] t_b[10]   = '{32'd5, 32'hFFFF_FFFF, 32'd1, 32'h8000_0000, 32'h0000_1234,
                               32'd1, 32'hF000_0000, 32'd0, 32'h0F0F_0F0F, 32'h1234_5678};
    logic [31:0] t_exp[10] = '{32'hFFFF_FFFE, 32'd1, 32'd1, 32'hF800_0000, 32'h1234_0000,
                               32'h0000_0010, 32'h00F0_0000, 32'hFFFF_FFFF, 32'hF00F_F00F, 32'd0};
    ms_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(t_op[i], t_a[i], t_b[i], 5'd1, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (es_alu_res !== t_exp[i]) begin
        n_fail++;
        $display("FAIL arith_%0d op=%0d: got %h, required %h", i, t_op[i], es_alu_res, t_exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] pa;
    ms_allowin = 1'b0;
    pa = pc_next;
    send(ALU_ADD, 32'd10, 32'd20, 5'd4, 1'b1);
    send(ALU_XOR, 32'hAAAA_0000, 32'h5555_FFFF, 5'd5, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (es_allowin !== 1'b0 || es_state !== EXE_TWO) begin
      n_fail++; $display("FAIL bp_full: got allowin=%b state=%0d, required 0/%0d", es_allowin, es_state, EXE_TWO);
    end
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (es_pc !== pa || es_allowin !== 1'b0) begin
      n_fail++; $display("FAIL bp_head_a: got pc=%h allowin=%b, required %h/0", es_pc, es_allowin, pa);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (es_pc !== pa + 32'd4 || es_to_ms_valid !== 1'b1 || es_allowin !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_head_b: got pc=%h valid=%b allowin=%b, required %h/1/1", es_pc, es_to_ms_valid, es_allowin, pa + 32'd4);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (es_to_ms_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_drained: got valid=%b, required 0", es_to_ms_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    ms_allowin = 1'b0;
    send(ALU_ADD, 32'd1, 32'd1, 5'd6, 1'b1);
    send(ALU_ADD, 32'd2, 32'd2, 5'd7, 1'b1);
    es_flush = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_alu_op = ALU_OR;
    ds_pc = 32'hBAD0_0000;
    exp_q.delete();
    @(posedge clk); #1;
    es_flush = 1'b0;
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1 || es_state !== EXE_EMPTY) begin
      n_fail++;
      $display("FAIL flush_two: got valid=%b allowin=%b state=%0d, required 0/1/0", es_to_ms_valid, es_allowin, es_state);
    end
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    // flush in ONE while a push would otherwise be accepted
    ms_allowin = 1'b0;
    send(ALU_ADD, 32'd3, 32'd3, 5'd8, 1'b1);
    es_flush = 1'b1;
    ds_to_es_valid = 1'b1;
    ds_pc = 32'hBAD0_0004;
    exp_q.delete();
    @(posedge clk); #1;
    es_flush = 1'b0;
    ds_to_es_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (es_to_ms_valid !== 1'b0 || es_state !== EXE_EMPTY) begin
      n_fail++; $display("FAIL flush_one: got valid=%b state=%0d, required 0/0", es_to_ms_valid, es_state);
    end
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_fwd;
    ms_allowin = 1'b1;
    send(ALU_ADD, 32'd1, 32'd2, 5'd0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (es_fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_dest0: got %b, required 0", es_fwd_valid);
    end
    @(posedge clk); #1;
    send(ALU_ADD, 32'd1, 32'd2, 5'd7, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (es_fwd_valid !== 1'b0) begin
      n_fail++; $display("FAIL fwd_we0: got %b, required 0", es_fwd_valid);
    end
    @(posedge clk); #1;
    send(ALU_OR, 32'h0000_00F0, 32'h0000_000F, 5'd9, 1'b1);
    @(negedge clk);
    n_cmp++;
`ifdef EXE_FWD_EN
    if (es_fwd_valid !== 1'b1 || es_fwd_dest !== 5'd9 || es_fwd_data !== 32'hFF) begin
      n_fail++;
      $display("FAIL fwd_on: got fv=%b dst=%0d data=%h, required 1/9/ff", es_fwd_valid, es_fwd_dest, es_fwd_data);
    end
`else
    if (es_fwd_valid !== 1'b0 || es_fwd_dest !== 5'd0) begin
      n_fail++; $display("FAIL fwd_off: got fv=%b dst=%0d, required 0/0", es_fwd_valid, es_fwd_dest);
    end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    ms_allowin = 1'b0;
    send(ALU_SUB, 32'd9, 32'd4, 5'd10, 1'b1);
    send(ALU_SUB, 32'd8, 32'd4, 5'd11, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_cmp++;
    if (es_allowin !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_allowin: got %b, required 0", es_allowin);
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_valid: got valid=%b allowin=%b, required 0/0", es_to_ms_valid, es_allowin);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (es_to_ms_valid !== 1'b0 || es_allowin !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_after: got valid=%b allowin=%b, required 0/1", es_to_ms_valid, es_allowin);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int start;
    ms_allowin = 1'b1;
    start = cyc;
    for (int i = 0; i < 8; i++)
      send(4'($urandom_range(0, 11)), $urandom, $urandom, 5'($urandom_range(0, 31)), 1'b1);
    n_cmp++;
    if (cyc - start !== 8) begin
      n_fail++; $display("FAIL throughput: got %0d cycles for 8 ops, required 8", cyc - start);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++)
      send(4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)));
    rand_bp = 1'b0;
    @(posedge clk); #1;
    ms_allowin = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_arith();
    test_backpressure();
    test_flush();
    test_fwd();
    test_reset_mid();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d entries never emerged, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
